// File: rtl/enum_stream_pkg.sv
// Shared types for the raw-code to typed-enum decoder.
//   color_e        : legal payload values (code 3 has no member)
//   state_e        : input-acceptance FSM states
//   is_legal_color : 1 when a raw 2-bit code names a color_e member
package enum_stream_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  function automatic bit is_legal_color(logic [1:0] code);
    return code inside {RED, GREEN, BLUE};
  endfunction

endpackage

// File: rtl/enum_skid_buf.sv
// Two-entry valid/ready buffer: output register plus one skid entry.
//   push/push_data : write one entry (caller only pushes when !skid_full)
//   skid_full      : skid entry occupied, upstream must stall
//   out_valid/out_ready/out_data : registered downstream stream
module enum_skid_buf
  import enum_stream_pkg::*;
#(
  parameter type T       = color_e,
  parameter T    RST_VAL = RED
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  output logic skid_full,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     skid_data;
  logic out_free;

  // Output register can take a new entry this edge.
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= RST_VAL;
      skid_full <= 1'b0;
      skid_data <= RST_VAL;
    end else if (out_free) begin
      if (skid_full) begin
        // Older skid entry goes first; no push possible while skid is full.
        out_valid <= 1'b1;
        out_data  <= skid_data;
        skid_full <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) out_data <= push_data;
      end
    end else if (push) begin
      skid_full <= 1'b1;
      skid_data <= push_data;
    end
  end

endmodule

// File: rtl/enum_stream_decoder.sv
// Validates raw 2-bit codes and forwards only legal ones as color_e.
//   in_valid/in_ready/in_code      : raw code input stream
//   out_valid/out_ready/out_color  : typed, registered output stream
//   err_pulse/last_bad_code        : illegal-code report
//   halted/clr_halt                : halt-on-error control (HALT_ON_ERR)
//   cnt_clr/legal_cnt/illegal_cnt  : saturating event counters
module enum_stream_decoder
  import enum_stream_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output color_e           out_color,
  output logic             err_pulse,
  output logic [1:0]       last_bad_code,
  output logic             halted,
  input  logic             clr_halt,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] legal_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  state_e state;
  logic   skid_full;
  logic   accept, legal, good_acc, bad_acc;
  color_e push_color;

  assign in_ready = (state == RUN) && !skid_full && !rst;
  assign accept   = in_valid && in_ready;
  assign legal    = is_legal_color(in_code);
  assign good_acc = accept && legal;
  assign bad_acc  = accept && !legal;
  // Cast only once the code is known to be a member.
  assign push_color = legal ? color_e'(in_code) : RED;

  enum_skid_buf #(.T(color_e), .RST_VAL(RED)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (good_acc),
    .push_data (push_color),
    .skid_full (skid_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_color)
  );

  // Halt FSM; an error accept beats clr_halt because clr_halt is only
  // looked at from HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: if (bad_acc && HALT_ON_ERR) begin
          state  <= HALT;
          halted <= 1'b1;
        end
        HALT: if (clr_halt) begin
          state  <= RUN;
          halted <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse     <= 1'b0;
      last_bad_code <= 2'd0;
    end else begin
      err_pulse <= bad_acc;
      if (bad_acc) last_bad_code <= in_code;
    end
  end

  // Saturating counters; clear drops a same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      legal_cnt   <= '0;
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      legal_cnt   <= '0;
      illegal_cnt <= '0;
    end else begin
      if (good_acc && legal_cnt != {CNT_W{1'b1}})  legal_cnt   <= legal_cnt + 1'b1;
      if (bad_acc && illegal_cnt != {CNT_W{1'b1}}) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_enum_stream_decoder.sv
// Bench for enum_stream_decoder: instance a (CNT_W=4, no halt) and
// instance b (CNT_W=8, halt on error) share code/out_ready/controls but
// have separate in_valid so b can hold a code while halted.
module tb_enum_stream_decoder;
  import enum_stream_pkg::*;

  logic clk, rst;
  logic a_iv, b_iv, out_ready, clr_halt, cnt_clr;
  logic [1:0] code;

  logic a_ir, a_ov, a_err, a_halt;
  color_e a_color;
  logic [1:0] a_bad;
  logic [3:0] a_lc, a_ic;

  logic b_ir, b_ov, b_err, b_halt;
  color_e b_color;
  logic [1:0] b_bad;
  logic [7:0] b_lc, b_ic;

  int checks = 0;
  int errors = 0;
  int a_errs = 0;
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  enum_stream_decoder #(.CNT_W(4), .HALT_ON_ERR(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_code(code),
    .out_valid(a_ov), .out_ready(out_ready), .out_color(a_color),
    .err_pulse(a_err), .last_bad_code(a_bad), .halted(a_halt),
    .clr_halt(clr_halt), .cnt_clr(cnt_clr), .legal_cnt(a_lc), .illegal_cnt(a_ic)
  );

  enum_stream_decoder #(.CNT_W(8), .HALT_ON_ERR(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_code(code),
    .out_valid(b_ov), .out_ready(out_ready), .out_color(b_color),
    .err_pulse(b_err), .last_bad_code(b_bad), .halted(b_halt),
    .clr_halt(clr_halt), .cnt_clr(cnt_clr), .legal_cnt(b_lc), .illegal_cnt(b_ic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes seen mid-cycle complete at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_ov && out_ready) begin
        if (q_a.size() == 0) chk("a_out_empty", a_ov, 1'b0);
        else chk("a_out", a_color, q_a.pop_front());
      end
      if (b_ov && out_ready) begin
        if (q_b.size() == 0) chk("b_out_empty", b_ov, 1'b0);
        else chk("b_out", b_color, q_b.pop_front());
      end
      if (a_iv && a_ir && is_legal_color(code)) q_a.push_back(code);
      if (b_iv && b_ir && is_legal_color(code)) q_b.push_back(code);
      if (a_err) a_errs++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=0", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; a_iv = 1'b0; b_iv = 1'b0; code = 2'd0;
    out_ready = 1'b1; clr_halt = 1'b0; cnt_clr = 1'b0;
    #3;
    chk("rst_ov", a_ov, 0);
    chk("rst_color", a_color, RED);
    chk("rst_err", a_err, 0);
    chk("rst_bad", a_bad, 0);
    chk("rst_halt", b_halt, 0);
    chk("rst_lc", a_lc, 0);
    chk("rst_ic", b_ic, 0);
    chk("rst_ir", a_ir, 0);
    tick; tick;
    rst = 1'b0;
    tick;
    chk("run_ir", a_ir, 1);

    // back-to-back legal codes
    for (int i = 0; i < 3; i++) begin
      a_iv = 1'b1; b_iv = 1'b1; code = 2'(i);
      tick;
    end
    a_iv = 1'b0; b_iv = 1'b0;
    chk("t1_ov", a_ov, 1);
    chk("t1_color", a_color, BLUE);
    tick; tick;
    chk("t1_q", q_a.size(), 0);
    chk("t1_lc", a_lc, 3);
    chk("t1_ic", a_ic, 0);
    chk("t1_blc", b_lc, 3);
    cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
    chk("clr_lc", a_lc, 0);

    // 1,3,2: a drops the 3, b halts on it
    a_iv = 1'b1; b_iv = 1'b1; code = 2'd1; tick;
    chk("t2_ir0", a_ir, 1);
    code = 2'd3; tick;
    chk("t2_ir1", a_ir, 1);
    chk("t2_err", a_err, 1);
    chk("t2_bad", a_bad, 3);
    chk("t2_ic", a_ic, 1);
    chk("t2_bhalt", b_halt, 1);
    chk("t2_bir", b_ir, 0);
    code = 2'd2; tick;
    a_iv = 1'b0;
    chk("t2_err_1cyc", a_err, 0);
    chk("t2_ahalt", a_halt, 0);
    tick; tick;
    chk("t2_bhold", b_ir, 0);
    chk("t2_bov", b_ov, 0);
    chk("t2_bq", q_b.size(), 0);
    clr_halt = 1'b1; tick; clr_halt = 1'b0;
    chk("t2_bclr", b_halt, 0);
    chk("t2_bir_back", b_ir, 1);
    tick; b_iv = 1'b0;
    tick; tick;
    chk("t2_qa", q_a.size(), 0);
    chk("t2_qb", q_b.size(), 0);
    chk("t2_errs", a_errs, 1);
    chk("t2_bic", b_ic, 1);

    // error and clr_halt together in RUN: error wins
    b_iv = 1'b1; code = 2'd3; clr_halt = 1'b1; tick;
    b_iv = 1'b0; clr_halt = 1'b0;
    chk("t4_errwin", b_halt, 1);
    clr_halt = 1'b1; tick; clr_halt = 1'b0;
    chk("t4_rel", b_halt, 0);

    // back-pressure: two entries absorbed, then stall, then in order
    out_ready = 1'b0; a_iv = 1'b1; b_iv = 1'b1; code = 2'd0; tick;
    chk("t3_ir0", a_ir, 1);
    code = 2'd1; tick;
    chk("t3_ir_full", a_ir, 0);
    chk("t3_ov", a_ov, 1);
    chk("t3_color", a_color, RED);
    code = 2'd2; tick;
    chk("t3_stall", a_ir, 0);
    chk("t3_stable", a_color, RED);
    out_ready = 1'b1; tick;
    chk("t3_drain", a_color, GREEN);
    chk("t3_ir_back", a_ir, 1);
    tick;
    a_iv = 1'b0; b_iv = 1'b0;
    tick; tick;
    chk("t3_qa", q_a.size(), 0);
    chk("t3_qb", q_b.size(), 0);
    chk("t3_lc", a_lc, 5);

    // saturation on 4-bit counter
    cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a_iv = 1'b1; b_iv = 1'b1; code = 2'(i % 3);
      tick;
    end
    chk("t5_sat", a_lc, 15);
    chk("t5_b20", b_lc, 20);
    code = 2'd1; cnt_clr = 1'b1; tick;
    a_iv = 1'b0; b_iv = 1'b0; cnt_clr = 1'b0;
    chk("t5_clrwin", a_lc, 0);
    chk("t5_bclrwin", b_lc, 0);
    tick; tick;
    chk("t5_q", q_a.size(), 0);

    // asynchronous reset with both entries occupied
    out_ready = 1'b0; a_iv = 1'b1; b_iv = 1'b1; code = 2'd0; tick;
    code = 2'd1; tick;
    a_iv = 1'b0; b_iv = 1'b0;
    chk("t6_full", a_ir, 0);
    chk("t6_ov", a_ov, 1);
    rst = 1'b1;
    q_a.delete(); q_b.delete();
    #1;
    chk("t6_rst_ov", a_ov, 0);
    chk("t6_rst_ir", a_ir, 0);
    chk("t6_rst_lc", a_lc, 0);
    chk("t6_rst_bov", b_ov, 0);
    tick;
    rst = 1'b0; out_ready = 1'b1;
    tick;
    a_iv = 1'b1; b_iv = 1'b1; code = 2'd2; tick;
    a_iv = 1'b0; b_iv = 1'b0;
    chk("t6_first", a_color, BLUE);
    tick; tick;
    chk("t6_qa", q_a.size(), 0);
    chk("t6_qb", q_b.size(), 0);
    chk("t6_lc", a_lc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enum_stream_decoder.md
# enum_stream_decoder

Receive-side counterpart of the enum-to-integral path. It accepts raw 2-bit codes on a valid/ready stream, checks each against the legal members of `color_e`, and forwards only legal values as typed enum values through a registered, back-pressurable output. Illegal codes are dropped, counted and reported, and can optionally halt the input. It sits between any raw-code producer (bus, CSR, deserializer) and typed consumers that must never see an out-of-range enum value.

## Interface
Parameters:
- `CNT_W`, default 8: width of the saturating event counters.
- `HALT_ON_ERR`, default 0: when 1, an illegal code halts input acceptance until `clr_halt`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: producer has a code.
- `in_ready`, output, 1: block accepts this cycle.
- `in_code`, input, 2: raw code.
- `out_valid`, output, 1: `out_color` valid.
- `out_ready`, input, 1: consumer accepts.
- `out_color`, output, `color_e`: decoded enum value.
- `err_pulse`, output, 1: one-cycle pulse per accepted illegal code.
- `last_bad_code`, output, 2: most recent illegal code.
- `halted`, output, 1: FSM is in HALT.
- `clr_halt`, input, 1: leave HALT.
- `cnt_clr`, input, 1: synchronous clear of both counters.
- `legal_cnt`, output, `CNT_W`: accepted legal codes.
- `illegal_cnt`, output, `CNT_W`: accepted illegal codes.

## Operation
- Legality: a code is legal iff it equals a declared member of `color_e` (`RED`=0, `GREEN`=1, `BLUE`=2). Code 3 is illegal.
- Conversion: an explicit cast `color_e'(in_code)` is applied only after the legality check passes. No implicit integral-to-enum assignment is allowed anywhere in the block.
- Accept: a code is accepted when `in_valid && in_ready` at a rising edge.
  - Legal codes enter the buffer.
  - Illegal codes never enter the buffer. On accept, `err_pulse` goes high, `last_bad_code` is loaded and `illegal_cnt` increments.
- Buffer: output register plus one skid entry, 2 entries total. FIFO order is strictly preserved.
  - `in_ready = (state==RUN) && !skid_valid && !rst`.
- FSM `state_e`, with two states:
  - RUN → HALT: an illegal code is accepted and `HALT_ON_ERR`=1.
  - HALT → RUN: `clr_halt`=1.
  - `clr_halt` is ignored in RUN.
  - Illegal accept and `clr_halt` in the same cycle in RUN: the next state is HALT (error wins).
  - In HALT, `in_ready`=0, but the buffer still drains to the output.
- Counters:
  - Saturate at 2^CNT_W−1 and never wrap.
  - `cnt_clr` wins over a same-cycle increment: the result is 0 and that event is not counted.
- Reset values:
  - `out_valid`=0, `out_color`=`RED`, `err_pulse`=0, `last_bad_code`=0, `halted`=0 (state RUN).
  - Both counters 0, skid empty.
  - `in_ready`=0 while `rst` is high.
- Reset mid-operation: all buffered data is discarded immediately (asynchronous). No output is emitted for it.

## Timing
- Latency: a legal code accepted at edge N with the output register free (empty, or draining at N) gives `out_valid`=1 with that value from edge N onward.
- Throughput: 1 code/cycle while `out_ready`=1.
- Back-pressure:
  - When `out_valid && !out_ready`, the next legal accept fills the skid entry. `in_ready` falls after that edge.
  - `in_ready` rises the cycle after the output drains the skid entry.
- `out_color` is stable while `out_valid && !out_ready`.
- `err_pulse`, `last_bad_code` and `illegal_cnt` all update at the accepting edge N and are visible during cycle N+1. `err_pulse` is high for exactly one cycle.
- `halted` rises at the same edge that accepts the offending code. It falls at the edge where `clr_halt` is sampled; `in_ready` can return in that next cycle.

## Structure
- Package `enum_stream_pkg` contains:
  - `color_e` (`logic [1:0]`: `RED`=0, `GREEN`=1, `BLUE`=2).
  - `state_e` (`RUN`, `HALT`).
  - Function `is_legal_color(logic [1:0])` returning bit.
- Sub-module `enum_skid_buf`: 2-entry valid/ready skid buffer, parameterized by payload type `T` (here `color_e`). It owns `out_valid`/`out_color` and the skid register.
- Top level contains the legality check, cast, FSM, counters and error capture.

## Test plan
- Reset, `out_ready`=1, send 0,1,2 back-to-back → `out_color` `RED`,`GREEN`,`BLUE` on consecutive cycles; `legal_cnt`=3, `illegal_cnt`=0.
- `HALT_ON_ERR`=0, send 1,3,2 → outputs `GREEN`,`BLUE` only; one `err_pulse`; `last_bad_code`=3; `illegal_cnt`=1; `in_ready` never drops.
- Hold `out_ready`=0 and offer 0,1,2 → exactly 2 accepted, then `in_ready`=0. Release → `RED`,`GREEN`,`BLUE` in order, none lost or duplicated.
- `HALT_ON_ERR`=1, send 1,3,2 → `GREEN` emitted, `halted`=1, `in_ready`=0, code 2 held at the input. Pulse `clr_halt` → `BLUE` emitted. Illegal code plus `clr_halt` in the same cycle in RUN → `halted`=1.
- `CNT_W`=4, 20 legal codes → `legal_cnt`=15 (saturated). `cnt_clr` coincident with a legal accept → `legal_cnt`=0.
- Assert `rst` while `out_valid`=1 and skid full → `out_valid`=0, `in_ready`=0 and counters 0 immediately. After release the first code sent is the first one output.
